// File: rtl/mul32_seq.sv
// mul32_seq: iterative unsigned 32x32->64 shift-add multiplier.
// The sum is produced by an external 32-bit combinational adder: this block
// drives its A/B/carry-in and folds sum/carry-out back into {hi, lo}, one
// multiplier bit per clock. Start/busy/done handshake, 33 cycles per op.
module mul32_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_s,
  input  logic               add_cout,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter value seen on the final RUN edge.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] w_add_a;

  // Adder A operand: the multiplicand is added only when the current
  // multiplier bit (lo[0]) is set. Always driven from registers, so no X.
  always_comb begin
    w_add_a = {WIDTH{1'b0}};
    if (r_lo[0]) begin
      w_add_a = r_mcand;
    end else begin
      w_add_a = {WIDTH{1'b0}};
    end
  end

  assign add_a   = w_add_a;
  assign add_b   = r_hi;
  assign add_cin = 1'b0;

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = {r_hi, r_lo};

  // Control FSM and datapath: accept, 32 shift-add steps, one-cycle done.
  // busy/done are registered alongside the state so they decode it exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_mcand <= {WIDTH{1'b0}};
      r_hi    <= {WIDTH{1'b0}};
      r_lo    <= {WIDTH{1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mcand <= mcand;
            r_hi    <= {WIDTH{1'b0}};
            r_lo    <= mplier;
            r_cnt   <= {CNT_W{1'b0}};
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        end
        ST_RUN: begin
          // 65-bit {carry, sum, lo} shifted right by one: the carry-out
          // lands in hi[MSB] and the sum LSB becomes a finished product bit.
          r_hi  <= {add_cout, add_s[WIDTH-1:1]};
          r_lo  <= {add_s[0], r_lo[WIDTH-1:1]};
          r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          if (r_cnt == LAST_CNT) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        ST_DONE: begin
          // A start here restarts immediately for back-to-back throughput.
          if (start) begin
            r_mcand <= mcand;
            r_hi    <= {WIDTH{1'b0}};
            r_lo    <= mplier;
            r_cnt   <= {CNT_W{1'b0}};
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul32_seq.sv
// tb_mul32_seq: directed bench for mul32_seq with a behavioural model of
// the external combinational 32-bit adder.
module tb_mul32_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_s;
  logic        add_cout;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int total = 0;
  int bad   = 0;

  mul32_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mcand    (mcand),
    .mplier   (mplier),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_s    (add_s),
    .add_cout (add_cout),
    .busy     (busy),
    .done     (done),
    .product  (product)
  );

  // external adder model
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mcand = 32'd0; mplier = 32'd0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (product !== 64'd0) begin bad++; $display("FAIL reset_product: got %h want 0", product); end
    total++; if (add_cin !== 1'b0) begin bad++; $display("FAIL reset_cin: got %b want 0", add_cin); end
    total++; if (add_a !== 32'd0) begin bad++; $display("FAIL reset_add_a: got %h want 0", add_a); end
    reset = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic();
    int n = 0;
    bit both = 1'b0;
    mcand = 32'd3; mplier = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mcand = 32'hAAAA_AAAA; mplier = 32'h5555_5555;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (done !== 1'b0) both = 1'b1;
      @(negedge clk);
    end
    total++; if (n !== 32) begin bad++; $display("FAIL basic_busy_len: got %0d want 32", n); end
    total++; if (both !== 1'b0) begin bad++; $display("FAIL basic_busy_done_overlap: got %b want 0", both); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL basic_done: got %b want 1", done); end
    total++; if (product !== 64'h0000_0000_0000_000F) begin bad++; $display("FAIL basic_product: got %h want %h", product, 64'hF); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle_busy: got %b want 0", busy); end
    total++; if (product !== 64'h0000_0000_0000_000F) begin bad++; $display("FAIL basic_product_hold: got %h want %h", product, 64'hF); end
  endtask

  task automatic test_max();
    int n = 0;
    bit cout_seen = 1'b0;
    mcand = 32'hFFFF_FFFF; mplier = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (add_cout === 1'b1) cout_seen = 1'b1;
      @(negedge clk);
    end
    total++; if (n !== 32) begin bad++; $display("FAIL max_busy_len: got %0d want 32", n); end
    total++; if (cout_seen !== 1'b1) begin bad++; $display("FAIL max_cout_seen: got %b want 1", cout_seen); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL max_done: got %b want 1", done); end
    total++; if (product !== 64'hFFFF_FFFE_0000_0001) begin bad++; $display("FAIL max_product: got %h want %h", product, 64'hFFFF_FFFE_0000_0001); end
    @(negedge clk);
  endtask

  task automatic test_zero();
    int n = 0;
    int nz = 0;
    mcand = 32'h1234_5678; mplier = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (add_a !== 32'd0) nz++;
      @(negedge clk);
    end
    total++; if (n !== 32) begin bad++; $display("FAIL zero_busy_len: got %0d want 32", n); end
    total++; if (nz !== 0) begin bad++; $display("FAIL zero_add_a_nonzero_cycles: got %0d want 0", nz); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_done: got %b want 1", done); end
    total++; if (product !== 64'd0) begin bad++; $display("FAIL zero_product: got %h want 0", product); end
    // swapped operands, restarted directly from DONE
    mcand = 32'd0; mplier = 32'h1234_5678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    total++; if (n !== 32) begin bad++; $display("FAIL swap_busy_len: got %0d want 32", n); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL swap_done: got %b want 1", done); end
    total++; if (product !== 64'd0) begin bad++; $display("FAIL swap_product: got %h want 0", product); end
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int n = 0;
    mcand = 32'h8000_0000; mplier = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (n == 10) begin
        start = 1'b1; mcand = 32'd7; mplier = 32'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    total++; if (n !== 32) begin bad++; $display("FAIL ignore_busy_len: got %0d want 32", n); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL ignore_done: got %b want 1", done); end
    total++; if (product !== 64'h0000_0001_0000_0000) begin bad++; $display("FAIL ignore_product: got %h want %h", product, 64'h1_0000_0000); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] mc [3];
    logic [31:0] mp [3];
    logic [63:0] ex [3];
    mc[0] = 32'h0000_FFFF; mp[0] = 32'h0001_0001; ex[0] = 64'h0000_0000_FFFF_FFFF;
    mc[1] = 32'h1234_5678; mp[1] = 32'h0000_0010; ex[1] = 64'h0000_0001_2345_6780;
    mc[2] = 32'hDEAD_BEEF; mp[2] = 32'h0000_0002; ex[2] = 64'h0000_0001_BD5B_7DDE;
    start = 1'b1; mcand = mc[0]; mplier = mp[0];
    for (int k = 0; k < 3; k++) begin
      int n = 0;
      @(negedge clk);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy_after_accept[%0d]: got %b want 1", k, busy); end
      if (k < 2) begin
        mcand = mc[k+1]; mplier = mp[k+1];
      end else begin
        start = 1'b0;
      end
      while (busy === 1'b1 && n < 40) begin
        n++;
        @(negedge clk);
      end
      total++; if (n !== 32) begin bad++; $display("FAIL b2b_busy_len[%0d]: got %0d want 32", k, n); end
      total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done[%0d]: got %b want 1", k, done); end
      total++; if (product !== ex[k]) begin bad++; $display("FAIL b2b_product[%0d]: got %h want %h", k, product, ex[k]); end
    end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_final_idle: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    bit saw_done = 1'b0;
    bit saw_busy = 1'b0;
    mcand = 32'h0001_0000; mplier = 32'h0001_0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (busy === 1'b1 && n < 17) begin
      n++;
      @(negedge clk);
    end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
    reset = 1'b1;
    #1;
    total++; if (product !== 64'd0) begin bad++; $display("FAIL rstmid_product: got %h want 0", product); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done: got %b want 0", done); end
    total++; if (add_a !== 32'd0 || add_b !== 32'd0) begin bad++; $display("FAIL rstmid_adder_ops: got %h/%h want 0/0", add_a, add_b); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done !== 1'b0) saw_done = 1'b1;
      if (busy !== 1'b0) saw_busy = 1'b1;
    end
    total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL rstmid_no_done: got %b want 0", saw_done); end
    total++; if (saw_busy !== 1'b0) begin bad++; $display("FAIL rstmid_stays_idle: got %b want 0", saw_busy); end
    mcand = 32'd6; mplier = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    total++; if (n !== 32) begin bad++; $display("FAIL rstmid_after_len: got %0d want 32", n); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL rstmid_after_done: got %b want 1", done); end
    total++; if (product !== 64'd42) begin bad++; $display("FAIL rstmid_after_product: got %h want %h", product, 64'd42); end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mcand = 32'd0; mplier = 32'd0;
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
